// File: rtl/vram_bus_adapter_pkg.sv
// VRAM bus adapter shared types.
// Size codes, FSM states and array geometry.
package vram_bus_adapter_pkg;

  localparam int VRAM_A_WORDS = 16384;
  localparam int VRAM_AW      = 14;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } bus_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ACK  = 2'd3
  } state_t;

  // Size code 3 behaves as a word access.
  function automatic bus_size_t size_norm(input logic [1:0] s);
    return (s == 2'd3) ? SZ_WORD : bus_size_t'(s);
  endfunction

endpackage

// File: rtl/vram_bus_adapter_if.sv
// GBA-side req/ack bus into the VRAM adapter.
// master = bus decoder, slave = adapter.
interface vram_bus_adapter_if #(
  parameter int AW = 14
);
  logic          bus_req;
  logic          bus_we;
  logic [1:0]    bus_size;
  logic [AW+1:0] bus_addr;
  logic [31:0]   bus_wdata;
  logic [31:0]   bus_rdata;
  logic          bus_ack;
  logic          bus_busy;

  modport master (
    output bus_req, bus_we, bus_size,
    output bus_addr, bus_wdata,
    input  bus_rdata, bus_ack, bus_busy
  );

  modport slave (
    input  bus_req, bus_we, bus_size,
    input  bus_addr, bus_wdata,
    output bus_rdata, bus_ack, bus_busy
  );
endinterface

// File: rtl/vram_bus_adapter_wr_merge.sv
// Read-modify-write merge of bus data into a VRAM word.
// Byte writes may be mirrored into the whole halfword.
module vram_bus_adapter_wr_merge
  import vram_bus_adapter_pkg::*;
#(
  parameter bit BYTE_DUP = 1'b1
) (
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  bus_size_t   size,
  input  logic [1:0]  lane,
  output logic [31:0] new_word
);

  // Replace only the addressed lanes, keep the rest.
  always_comb begin
    new_word = old_word;
    unique case (1'b1)
      size == SZ_BYTE: begin
        if (BYTE_DUP) begin
          if (lane[1]) new_word[31:16] = {2{wdata[7:0]}};
          else         new_word[15:0]  = {2{wdata[7:0]}};
        end else begin
          new_word[{lane, 3'b000} +: 8] = wdata[7:0];
        end
      end
      size == SZ_HALF: begin
        if (lane[1]) new_word[31:16] = wdata[15:0];
        else         new_word[15:0]  = wdata[15:0];
      end
      default: new_word = wdata;
    endcase
  end

endmodule

// File: rtl/vram_bus_adapter.sv
// GBA bus to BG VRAM word-port adapter.
// Word reads, word writes and sub-word RMW writes.
module vram_bus_adapter
  import vram_bus_adapter_pkg::*;
#(
  parameter int AW       = VRAM_AW,
  parameter bit BYTE_DUP = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  vram_bus_adapter_if.slave   bus,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_we,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  state_t        state_q, state_d;
  logic          we_q, we_d;
  bus_size_t     size_q, size_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   cap_q, cap_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   merged;
  logic [31:0]   rd_ext;
  bus_size_t     req_size;

  assign req_size = size_norm(bus.bus_size);

  vram_bus_adapter_wr_merge #(
    .BYTE_DUP (BYTE_DUP)
  ) u_merge (
    .old_word (cap_q),
    .wdata    (wdata_q),
    .size     (size_q),
    .lane     (addr_q[1:0]),
    .new_word (merged)
  );

  // State register and latched transaction fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state: full words skip the read phase.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.bus_req) begin
          if (bus.bus_we && req_size == SZ_WORD) state_d = WR;
          else                                   state_d = RD;
        end
      end
      RD:      state_d = we_q ? WR : ACK;
      WR:      state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane extraction of the word being read.
  always_comb begin
    unique case (1'b1)
      size_q == SZ_BYTE:
        rd_ext = {24'h0, mem_rdata[{addr_q[1:0], 3'b000} +: 8]};
      size_q == SZ_HALF:
        rd_ext = {16'h0, addr_q[1] ? mem_rdata[31:16]
                                   : mem_rdata[15:0]};
      default: rd_ext = mem_rdata;
    endcase
  end

  // Latch request on accept, capture array word in RD.
  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && bus.bus_req) begin
      we_d    = bus.bus_we;
      size_d  = req_size;
      wdata_d = bus.bus_wdata;
      addr_d  = bus.bus_addr;
      if (req_size == SZ_HALF) addr_d[0]   = 1'b0;
      if (req_size == SZ_WORD) addr_d[1:0] = 2'b00;
    end
    if (state_q == RD) begin
      cap_d = mem_rdata;
      if (!we_q) rdata_d = rd_ext;
    end
  end

  // Outputs; strobes are masked in a reset cycle.
  always_comb begin
    mem_addr      = addr_q[AW+1:2];
    mem_we        = (state_q == WR) && !rst;
    mem_wdata     = (state_q == WR) ? merged : 32'h0;
    bus.bus_ack   = (state_q == ACK) && !rst;
    bus.bus_busy  = (state_q != IDLE);
    bus.bus_rdata = rdata_q;
  end

endmodule

// File: tb/tb_vram_bus_adapter.sv
// Bench for vram_bus_adapter: both BYTE_DUP settings
// driven in lockstep against a byte-level model.
module tb_vram_bus_adapter;
  import vram_bus_adapter_pkg::*;

  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_bus_adapter_if #(.AW(AW)) b1 ();
  vram_bus_adapter_if #(.AW(AW)) b0 ();

  logic [AW-1:0] ma1, ma0;
  logic          mw1, mw0;
  logic [31:0]   md1, md0, mr1, mr0;

  vram_bus_adapter #(.AW(AW), .BYTE_DUP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1),
    .mem_addr(ma1), .mem_we(mw1),
    .mem_wdata(md1), .mem_rdata(mr1)
  );

  vram_bus_adapter #(.AW(AW), .BYTE_DUP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0),
    .mem_addr(ma0), .mem_we(mw0),
    .mem_wdata(md0), .mem_rdata(mr0)
  );

  bit [31:0] m1 [VRAM_A_WORDS];
  bit [31:0] m0 [VRAM_A_WORDS];
  bit [31:0] r1 [VRAM_A_WORDS];
  bit [31:0] r0 [VRAM_A_WORDS];

  logic          pk_en = 1'b0;
  logic [AW-1:0] pk_a  = '0;
  logic [31:0]   pk_d  = '0;
  int            wc1 = 0, wc0 = 0;

  assign mr1 = m1[ma1];
  assign mr0 = m0[ma0];

  always @(posedge clk) begin
    if (pk_en) begin
      m1[pk_a] <= pk_d;
      m0[pk_a] <= pk_d;
    end
    if (mw1) begin
      m1[ma1] <= md1;
      wc1++;
    end
    if (mw0) begin
      m0[ma0] <= md0;
      wc0++;
    end
  end

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] lrd1 = '0, lrd0 = '0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl_write(
    input logic [31:0] old, input logic [31:0] wd,
    input int sz, input int a, input bit dup);
    logic [7:0] by [4];
    int h;
    for (int i = 0; i < 4; i++) by[i] = old[8*i +: 8];
    if (sz == 3) sz = 2;
    h = a & 2;
    if (sz == 2) begin
      for (int i = 0; i < 4; i++) by[i] = wd[8*i +: 8];
    end else if (sz == 1) begin
      by[h]   = wd[7:0];
      by[h+1] = wd[15:8];
    end else if (dup) begin
      by[h]   = wd[7:0];
      by[h+1] = wd[7:0];
    end else begin
      by[a & 3] = wd[7:0];
    end
    return {by[3], by[2], by[1], by[0]};
  endfunction

  function automatic logic [31:0] mdl_read(
    input logic [31:0] w, input int sz, input int a);
    if (sz == 0) return (w >> (8 * (a & 3))) & 32'hFF;
    if (sz == 1) return (w >> (8 * (a & 2))) & 32'hFFFF;
    return w;
  endfunction

  task automatic drive(input bit req, input bit we,
                       input int sz, input int a,
                       input logic [31:0] wd);
    b1.bus_req   = req;  b0.bus_req   = req;
    b1.bus_we    = we;   b0.bus_we    = we;
    b1.bus_size  = 2'(sz); b0.bus_size = 2'(sz);
    b1.bus_addr  = 16'(a); b0.bus_addr = 16'(a);
    b1.bus_wdata = wd;   b0.bus_wdata = wd;
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    @(negedge clk);
    pk_en = 1'b1;
    pk_a  = 14'(idx);
    pk_d  = v;
    @(posedge clk);
    #1 pk_en = 1'b0;
    r1[idx] = v;
    r0[idx] = v;
  endtask

  task automatic do_txn(input bit we, input int sz,
                        input int a, input logic [31:0] wd);
    int lat, exp_lat, idx, w1s, w0s;
    idx = (a >> 2) & 16'h3FFF;
    w1s = wc1;
    w0s = wc0;
    exp_lat = (we && sz < 2) ? 3 : 2;
    if (we) begin
      r1[idx] = mdl_write(r1[idx], wd, sz, a, 1'b1);
      r0[idx] = mdl_write(r0[idx], wd, sz, a, 1'b0);
    end else begin
      lrd1 = mdl_read(r1[idx], sz, a);
      lrd0 = mdl_read(r0[idx], sz, a);
    end
    @(negedge clk);
    drive(1'b1, we, sz, a, wd);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 0, 0, 32'h0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("busy", 32'(b1.bus_busy), 32'd1);
    end while (!b1.bus_ack && lat < 8);
    check("lat", lat, exp_lat);
    check("ack0", 32'(b0.bus_ack), 32'd1);
    check("rd1", b1.bus_rdata, lrd1);
    check("rd0", b0.bus_rdata, lrd0);
    check("mem1", m1[idx], r1[idx]);
    check("mem0", m0[idx], r0[idx]);
    check("wc1", wc1 - w1s, we ? 1 : 0);
    check("wc0", wc0 - w0s, we ? 1 : 0);
  endtask

  initial begin
    int n, g, w1s;
    drive(1'b0, 1'b0, 0, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ack", 32'(b1.bus_ack), 32'd0);
    check("rst_busy", 32'(b1.bus_busy), 32'd0);
    check("rst_we", 32'(mw1), 32'd0);
    check("rst_rdata", b1.bus_rdata, 32'd0);
    check("rst_maddr", 32'(ma1), 32'd0);
    check("rst_mwdata", md1, 32'd0);

    do_txn(1'b1, 2, 'h10, 32'hDEADBEEF);
    check("w_word", m1[4], 32'hDEADBEEF);

    poke(4, 32'h11223344);
    do_txn(1'b1, 1, 'h12, 32'h0000ABCD);
    check("w_half", m1[4], 32'hABCD3344);

    poke(4, 32'h11223344);
    do_txn(1'b1, 0, 'h11, 32'h0000005A);
    check("w_bdup", m1[4], 32'h11225A5A);
    check("w_bnodup", m0[4], 32'h11225A44);

    poke(4, 32'h11223344);
    do_txn(1'b0, 0, 'h13, 32'h0);
    check("r_byte", b1.bus_rdata, 32'h00000011);
    do_txn(1'b0, 1, 'h10, 32'h0);
    check("r_half", b1.bus_rdata, 32'h00003344);
    do_txn(1'b0, 2, 'h12, 32'h0);
    check("r_word", b1.bus_rdata, 32'h11223344);

    do_txn(1'b1, 3, 'hFFFC, 32'h0BADCAFE);
    do_txn(1'b0, 0, 'hFFFF, 32'h0);

    // Reset while a sub-word write sits in WR.
    poke(5, 32'hCAFEF00D);
    w1s = wc1;
    @(negedge clk);
    drive(1'b1, 1'b1, 1, 'h14, 32'h1234);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 0, 0, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rstwr_we", 32'(mw1), 32'd0);
    check("rstwr_ack", 32'(b1.bus_ack), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rstwr_busy", 32'(b1.bus_busy), 32'd0);
    check("rstwr_ack2", 32'(b1.bus_ack), 32'd0);
    check("rstwr_mem", m1[5], 32'hCAFEF00D);
    check("rstwr_wc", wc1 - w1s, 0);
    lrd1 = '0;
    lrd0 = '0;
    check("rstwr_rd", b1.bus_rdata, lrd1);

    // Request held across ack starts a second transaction.
    w1s = wc1;
    @(negedge clk);
    drive(1'b1, 1'b1, 2, 'h20, 32'h13572468);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b1.bus_ack && n < 8);
    check("hold_first", 32'(b1.bus_ack), 32'd1);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!b1.bus_ack && g < 10);
    drive(1'b0, 1'b0, 0, 0, 32'h0);
    check("hold_gap", g, 3);
    check("hold_wc", wc1 - w1s, 2);
    r1[8] = 32'h13572468;
    r0[8] = 32'h13572468;
    check("hold_mem", m1[8], r1[8]);

    // Request pulsed while busy must be ignored.
    poke(9, 32'h600DF00D);
    w1s = wc1;
    @(negedge clk);
    drive(1'b1, 1'b0, 2, 'h24, 32'h0);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 0, 0, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b1, 2, 'h24, 32'hFFFFFFFF);
    @(negedge clk);
    check("tog_ack", 32'(b1.bus_ack), 32'd1);
    check("tog_rd", b1.bus_rdata, 32'h600DF00D);
    drive(1'b0, 1'b0, 0, 0, 32'h0);
    repeat (4) @(negedge clk);
    check("tog_busy", 32'(b1.bus_busy), 32'd0);
    check("tog_wc", wc1 - w1s, 0);
    check("tog_mem", m1[9], 32'h600DF00D);
    lrd1 = 32'h600DF00D;
    lrd0 = 32'h600DF00D;

    for (int i = 0; i < 150; i++) begin
      int w, a;
      w = $urandom_range(0, 8);
      if (w == 8) w = 16383;
      a = (w << 2) | $urandom_range(0, 3);
      do_txn(1'($urandom_range(0, 1)),
             $urandom_range(0, 3), a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
